simotor_multi: RTL and testbench

//  Parametrised N-channel DC motor + quadrature encoder simulator for PID/PWM bench and on-chip loopback.
//  Per channel: bridge PWM (F,R) in; simulated speed and position; quadrature A/B out.

---
 rtl/simotor_multi.sv | 138 +++++++++++++
 tb/tb_simotor_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simotor_multi.sv
// rtl/simotor_multi.sv - N-channel DC motor + quadrature encoder simulator; SIMOTOR_INDEX_EN enables the index pulse Z.
module simotor_multi #(
    parameter int CHANNELS    = 4,
    parameter int W           = 32,
    parameter int POWER       = 512,
    parameter int SPEED_SHIFT = 16,
    parameter int FRICTION    = 60,
    parameter int BRAKE_SHIFT = 2,
    parameter int PRESCALER   = 0
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] F,
    input  logic [CHANNELS-1:0] R,
    output logic [CHANNELS-1:0] A,
    output logic [CHANNELS-1:0] B,
    output logic [CHANNELS-1:0] Z,
    output logic                TICK
);
    localparam int WX = W + 2;
    localparam logic signed [WX-1:0] POWER_X = WX'(POWER);
    localparam logic signed [WX-1:0] FRIC_X  = WX'(FRICTION);
    localparam logic signed [WX-1:0] SAT_X   = {3'b000, {(W-1){1'b1}}};

    logic [CHANNELS-1:0] f_q, r_q, a_q, b_q;
    logic                tick_q;
    logic                tick_now;
    logic signed [W-1:0] speed_q [CHANNELS];
    logic signed [W-1:0] speed_d [CHANNELS];
    logic        [W-1:0] pos_q   [CHANNELS];
    logic        [W-1:0] pos_d   [CHANNELS];

    // All losses are taken on the magnitude so both directions decay identically.
    function automatic logic signed [W-1:0] next_speed(
        input logic signed [W-1:0] speed,
        input logic                fwd,
        input logic                rev
    );
        logic signed [WX-1:0] cur, sp, mag, res;
        cur = {{2{speed[W-1]}}, speed};
        mag = cur[WX-1] ? -cur : cur;
        if (fwd && rev)
            sp = cur[WX-1] ? cur + (mag >> BRAKE_SHIFT) : cur - (mag >> BRAKE_SHIFT);
        else if (fwd)
            sp = cur + POWER_X;
        else if (rev)
            sp = cur - POWER_X;
        else
            sp = cur;
        mag = sp[WX-1] ? -sp : sp;
        if (mag <= FRIC_X)
            res = '0;
        else if (sp[WX-1])
            res = sp + (mag >> SPEED_SHIFT) + FRIC_X;
        else
            res = sp - (mag >> SPEED_SHIFT) - FRIC_X;
        if (res > SAT_X)
            res = SAT_X;
        else if (res < -SAT_X)
            res = -SAT_X;
        return res[W-1:0];
    endfunction

    generate
        if (PRESCALER == 0) begin : g_no_presc
            assign tick_now = 1'b1;
        end else begin : g_presc
            logic [PRESCALER-1:0] presc_q;
            always_ff @(posedge CLOCK) begin
                if (RESET)
                    presc_q <= '0;
                else
                    presc_q <= presc_q + PRESCALER'(1);
            end
            assign tick_now = (presc_q == '0);
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            speed_d[c] = next_speed(speed_q[c], f_q[c], r_q[c]);
            pos_d[c]   = pos_q[c] + speed_q[c];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            f_q    <= '0;
            r_q    <= '0;
            a_q    <= '1;
            b_q    <= '0;
            tick_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                speed_q[c] <= '0;
                pos_q[c]   <= '0;
            end
        end else begin
            f_q    <= F;
            r_q    <= R;
            tick_q <= tick_now;
            if (tick_now) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    speed_q[c] <= speed_d[c];
                    pos_q[c]   <= pos_d[c];
                    // Gray code of the position quadrant: 00->A1B0, 01->A1B1, 10->A0B1, 11->A0B0.
                    a_q[c]     <= ~pos_q[c][W-1];
                    b_q[c]     <= pos_q[c][W-1] ^ pos_q[c][W-2];
                end
            end
        end
    end

`ifdef SIMOTOR_INDEX_EN
    logic [CHANNELS-1:0] z_q;

    function automatic logic crosses(input logic [1:0] q_old, input logic [1:0] q_new);
        return ((q_old == 2'b11) && (q_new == 2'b00)) || ((q_old == 2'b00) && (q_new == 2'b11));
    endfunction

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            z_q <= '0;
        end else if (tick_now) begin
            for (int c = 0; c < CHANNELS; c++)
                z_q[c] <= crosses(pos_q[c][W-1:W-2], pos_d[c][W-1:W-2]);
        end
    end

    assign Z = z_q;
`else
    assign Z = '0;
`endif

    assign A    = a_q;
    assign B    = b_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_simotor_multi.sv
// tb/tb_simotor_multi.sv - scoreboard bench for simotor_multi: three builds driven in parallel against an integer model.
module tb_simotor_multi;
`ifdef SIMOTOR_INDEX_EN
    localparam bit INDEX_EN = 1'b1;
`else
    localparam bit INDEX_EN = 1'b0;
`endif
    localparam int NDUT = 3;
    localparam int FRIC [NDUT] = '{60, 600, 60};
    localparam int PREP [NDUT] = '{0, 0, 2};
    localparam int ENC_OF [4]  = '{1, 3, 2, 0};

    typedef struct packed {
        logic [2:0]             tick;
        logic [2:0][1:0]        a;
        logic [2:0][1:0]        b;
        logic [2:0][1:0]        z;
        logic [2:0][1:0][15:0]  spd;
        logic [2:0][1:0][15:0]  pos;
    } exp_t;

    logic       clk;
    logic       rst = 1'b1;
    logic [1:0] f_in = '0;
    logic [1:0] r_in = '0;

    logic [2:0][1:0]       act_a, act_b, act_z;
    logic [2:0]            act_tick;
    logic [2:0][1:0][15:0] act_spd, act_pos;

    int   n_assert = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;
    exp_t sb [$];

    int       m_spd   [NDUT][2];
    int       m_pos   [NDUT][2];
    int       m_enc   [NDUT][2];
    bit       m_z     [NDUT][2];
    bit       m_tick  [NDUT];
    int       m_presc [NDUT];
    bit [1:0] m_f     [NDUT];
    bit [1:0] m_r     [NDUT];

    simotor_multi #(.CHANNELS(2), .W(16), .POWER(512), .SPEED_SHIFT(4), .FRICTION(60),
                    .BRAKE_SHIFT(1), .PRESCALER(0)) dut0 (
        .CLOCK(clk), .RESET(rst), .F(f_in), .R(r_in),
        .A(act_a[0]), .B(act_b[0]), .Z(act_z[0]), .TICK(act_tick[0]));
    simotor_multi #(.CHANNELS(2), .W(16), .POWER(512), .SPEED_SHIFT(4), .FRICTION(600),
                    .BRAKE_SHIFT(1), .PRESCALER(0)) dut1 (
        .CLOCK(clk), .RESET(rst), .F(f_in), .R(r_in),
        .A(act_a[1]), .B(act_b[1]), .Z(act_z[1]), .TICK(act_tick[1]));
    simotor_multi #(.CHANNELS(2), .W(16), .POWER(512), .SPEED_SHIFT(4), .FRICTION(60),
                    .BRAKE_SHIFT(1), .PRESCALER(2)) dut2 (
        .CLOCK(clk), .RESET(rst), .F(f_in), .R(r_in),
        .A(act_a[2]), .B(act_b[2]), .Z(act_z[2]), .TICK(act_tick[2]));

    for (genvar c = 0; c < 2; c++) begin : g_act
        assign act_spd[0][c] = dut0.speed_q[c];
        assign act_spd[1][c] = dut1.speed_q[c];
        assign act_spd[2][c] = dut2.speed_q[c];
        assign act_pos[0][c] = dut0.pos_q[c];
        assign act_pos[1][c] = dut1.pos_q[c];
        assign act_pos[2][c] = dut2.pos_q[c];
    end

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int d, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d ch%0d @%0t: got %0d, expected %0d", nm, d, c, $time, act, exp);
        end
    endtask

    function automatic int physics(input int s, input bit fw, input bit rv, input int fric);
        int sp, m, res;
        if (fw && rv) begin
            m  = (s < 0 ? -s : s) / 2;
            sp = (s < 0) ? s + m : s - m;
        end else begin
            sp = s + ((fw && !rv) ? 512 : ((rv && !fw) ? -512 : 0));
        end
        m = (sp < 0) ? -sp : sp;
        if (m <= fric) return 0;
        res = (sp > 0) ? sp - m / 16 - fric : sp + m / 16 + fric;
        if (res > 32767) res = 32767;
        if (res < -32767) res = -32767;
        return res;
    endfunction

    // Advance the model by one clock edge with the inputs about to be sampled, and queue the result.
    task automatic model_step(input bit rs, input bit [1:0] fv, input bit [1:0] rv);
        exp_t e;
        int   q_old, q_new, np;
        for (int d = 0; d < NDUT; d++) begin
            if (rs) begin
                m_tick[d]  = 1'b0;
                m_presc[d] = 0;
                m_f[d]     = '0;
                m_r[d]     = '0;
                for (int c = 0; c < 2; c++) begin
                    m_spd[d][c] = 0;
                    m_pos[d][c] = 0;
                    m_enc[d][c] = 1;
                    m_z[d][c]   = 1'b0;
                end
            end else begin
                m_tick[d]  = (m_presc[d] == 0);
                m_presc[d] = (m_presc[d] + 1) % (1 << PREP[d]);
                if (m_tick[d]) begin
                    for (int c = 0; c < 2; c++) begin
                        q_old = m_pos[d][c] / 16384;
                        np    = ((m_pos[d][c] + m_spd[d][c]) % 65536 + 65536) % 65536;
                        q_new = np / 16384;
                        m_enc[d][c] = ENC_OF[q_old];
                        m_z[d][c]   = INDEX_EN && ((q_old == 3 && q_new == 0) || (q_old == 0 && q_new == 3));
                        m_spd[d][c] = physics(m_spd[d][c], m_f[d][c], m_r[d][c], FRIC[d]);
                        m_pos[d][c] = np;
                    end
                end
                m_f[d] = fv;
                m_r[d] = rv;
            end
            e.tick[d] = m_tick[d];
            for (int c = 0; c < 2; c++) begin
                e.a[d][c]   = m_enc[d][c][0];
                e.b[d][c]   = m_enc[d][c][1];
                e.z[d][c]   = m_z[d][c];
                e.spd[d][c] = 16'(m_spd[d][c]);
                e.pos[d][c] = 16'(m_pos[d][c]);
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive(input bit rs, input bit [1:0] fv, input bit [1:0] rv);
        @(negedge clk);
        rst  = rs;
        f_in = fv;
        r_in = rv;
        model_step(rs, fv, rv);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (sb.size() == 0) begin
                chk("sb_underflow", 0, 0, 1, 0);
                continue;
            end
            e = sb.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                chk("tick", d, 0, act_tick[d], e.tick[d]);
                for (int c = 0; c < 2; c++) begin
                    chk("enc_a", d, c, act_a[d][c], e.a[d][c]);
                    chk("enc_b", d, c, act_b[d][c], e.b[d][c]);
                    chk("index_z", d, c, act_z[d][c], e.z[d][c]);
                    chk("speed", d, c, act_spd[d][c], e.spd[d][c]);
                    chk("pos", d, c, act_pos[d][c], e.pos[d][c]);
                end
            end
        end
    end

    initial begin
        bit [1:0] fr, rr;
        int       hold;

        // Reset state
        drive(1, 2'b00, 2'b00); at_edge();
        chk("rst_a", 0, 0, act_a[0], 2'b11);
        chk("rst_b", 0, 0, act_b[0], 2'b00);
        chk("rst_z", 0, 0, act_z[0], 2'b00);
        chk("rst_tick", 0, 0, act_tick[0], 0);
        chk("rst_spd", 0, 0, act_spd[0], 0);
        chk("rst_pos", 0, 1, act_pos[0][1], 0);

        // Forward drive, then brake into the deadband
        drive(0, 2'b01, 2'b00); at_edge();
        drive(0, 2'b01, 2'b00); at_edge();
        chk("fwd_spd1", 0, 0, act_spd[0][0], 420);
        chk("fwd_pos1", 0, 0, act_pos[0][0], 0);
        drive(0, 2'b01, 2'b01); at_edge();
        chk("fwd_spd2", 0, 0, act_spd[0][0], 814);
        chk("fwd_pos2", 0, 0, act_pos[0][0], 420);
        chk("ch1_idle", 0, 1, act_spd[0][1], 0);
        drive(0, 2'b01, 2'b01); at_edge();
        chk("brk_spd1", 0, 0, act_spd[0][0], 322);
        chk("fwd_pos3", 0, 0, act_pos[0][0], 1234);
        drive(0, 2'b01, 2'b01); at_edge();
        chk("brk_spd2", 0, 0, act_spd[0][0], 91);
        drive(0, 2'b01, 2'b01); at_edge();
        chk("brk_spd3", 0, 0, act_spd[0][0], 0);
        drive(0, 2'b01, 2'b01); at_edge();
        chk("brk_hold", 0, 0, act_spd[0][0], 0);

        // Reverse from reset: position wraps below zero
        drive(1, 2'b00, 2'b00); at_edge();
        drive(0, 2'b00, 2'b01); at_edge();
        drive(0, 2'b00, 2'b01); at_edge();
        chk("rev_spd", 0, 0, act_spd[0][0], 16'd65116);
        drive(0, 2'b00, 2'b01); at_edge();
        chk("rev_pos", 0, 0, act_pos[0][0], 16'd65116);
        chk("rev_z", 0, 0, act_z[0][0], INDEX_EN ? 1 : 0);
        drive(0, 2'b00, 2'b01); at_edge();
        chk("rev_a", 0, 0, act_a[0][0], 0);
        chk("rev_b", 0, 0, act_b[0][0], 0);
        chk("rev_z_clr", 0, 0, act_z[0][0], 0);

        // Heavy friction build never leaves standstill; prescaled build ticks every 4th clock
        drive(1, 2'b00, 2'b00); at_edge();
        for (int i = 0; i < 20; i++) begin
            drive(0, 2'b11, 2'b00); at_edge();
            chk("stall_spd", 1, 0, act_spd[1][0], 0);
            chk("stall_a", 1, 0, act_a[1], 2'b11);
            chk("stall_b", 1, 0, act_b[1], 2'b00);
            chk("presc_tick", 2, 0, act_tick[2], (i % 4 == 0) ? 1 : 0);
        end
        drive(1, 2'b11, 2'b00); at_edge();
        chk("presc_rst_tick", 2, 0, act_tick[2], 0);
        chk("presc_rst_spd", 2, 0, act_spd[2][0], 0);
        chk("presc_rst_pos", 2, 0, act_pos[2][0], 0);
        drive(0, 2'b11, 2'b00); at_edge();
        chk("presc_resume", 2, 0, act_tick[2], 1);

        // Randomised run with held commands and occasional resets
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                fr   = 2'($urandom);
                rr   = 2'($urandom);
                hold = $urandom_range(1, 40);
            end
            hold--;
            drive(($urandom_range(0, 299) == 0), fr, rr);
        end

        @(posedge clk);
        #3;
        done = 1'b1;
        chk("sb_drain", 0, 0, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
